// File: rtl/iopmp_check_arbiter_pkg.sv
// Shared types and widths for the IOPMP check arbiter: access types, arbiter
// FSM states and address/entry-index widths used across the check path.
package iopmp_check_arbiter_pkg;

   localparam int unsigned IOPMP_ADDR_W = 34;
   localparam int unsigned IOPMP_IDX_W  = 9;
   localparam int unsigned SourceWidth  = 8;
   localparam int unsigned IOPMP_REQ_W  = 2;

   typedef enum logic [1:0] {
      IOPMP_READ    = 2'd0,
      IOPMP_WRITE   = 2'd1,
      IOPMP_EXECUTE = 2'd2
   } iopmp_req_e;

   typedef enum logic [1:0] {
      ARB_RUN   = 2'd0,
      ARB_DRAIN = 2'd1,
      ARB_HOLD  = 2'd2
   } arb_state_e;

   // Index width for a channel count; a single channel still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/iopmp_check_arbiter_rr.sv
// Combinational round-robin pick: first eligible channel at or after the
// pointer, wrapping. The pointer itself is owned by the parent.
module iopmp_check_arbiter_rr
   import iopmp_check_arbiter_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_vld
);

   int unsigned cand_s;
   logic        found_s;

   // Scan N candidates starting at ptr; the first eligible one wins.
   always_comb begin
      grant     = {N{1'b0}};
      grant_idx = {IW{1'b0}};
      found_s   = 1'b0;
      cand_s    = 32'd0;
      for (int unsigned i = 0; i < N; i++) begin
         cand_s = 32'(ptr) + i;
         cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
         if (!found_s && eligible[cand_s[IW-1:0]]) begin
            found_s                 = 1'b1;
            grant[cand_s[IW-1:0]]   = 1'b1;
            grant_idx               = cand_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
      grant_vld = found_s;
   end

endmodule

// File: rtl/iopmp_check_arbiter.sv
// Shares one IOPMP check pipeline among several request channels. Round-robin
// grant, one outstanding check per channel, result routed back to its owner
// after a fixed checker latency. Quiesces the checker for table rewrites.
module iopmp_check_arbiter
   import iopmp_check_arbiter_pkg::*;
#(
   parameter int unsigned IOPMPNumChan = 3,
   parameter int unsigned CHECK_LAT    = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [IOPMPNumChan-1:0]                    req_valid_i,
   output logic [IOPMPNumChan-1:0]                    req_ready_o,
   input  logic [IOPMPNumChan-1:0][IOPMP_ADDR_W-1:0]  req_addr_i,
   input  logic [IOPMPNumChan-1:0][IOPMP_REQ_W-1:0]   req_type_i,
   input  logic [IOPMPNumChan-1:0][SourceWidth-1:0]   req_rrid_i,
   output logic                                       chk_valid_o,
   output logic [IOPMP_ADDR_W-1:0]                    chk_addr_o,
   output iopmp_req_e                                 chk_type_o,
   output logic [SourceWidth-1:0]                     chk_rrid_o,
   input  logic                                       chk_err_i,
   input  logic [IOPMP_IDX_W-1:0]                     chk_idx_i,
   output logic [IOPMPNumChan-1:0]                    rsp_valid_o,
   output logic [IOPMPNumChan-1:0]                    rsp_err_o,
   output logic [IOPMPNumChan-1:0][IOPMP_IDX_W-1:0]   rsp_idx_o,
   input  logic                                       cfg_upd_req_i,
   output logic                                       cfg_upd_ack_o
);

   localparam int unsigned CW = idx_width(IOPMPNumChan);

   arb_state_e                       state_r, state_next_s;
   logic [CW-1:0]                    ptr_r, ptr_next_s;
   logic [IOPMPNumChan-1:0]          busy_r, eligible_s, grant_s, rsp_clr_s;
   logic [CW-1:0]                    grant_idx_s;
   logic                             grant_vld_s, grant_en_s, ack_next_s, ack_r;
   logic                             inflight_s, res_vld_s;
   logic [CW-1:0]                    res_chan_s;
   // Stage 0 is the issue cycle; stage CHECK_LAT is where the checker answers.
   logic [CHECK_LAT:0]               pipe_vld_r;
   logic [CHECK_LAT:0][CW-1:0]       pipe_chan_r;
   logic [IOPMP_ADDR_W-1:0]          chk_addr_r;
   iopmp_req_e                       chk_type_r;
   logic [SourceWidth-1:0]           chk_rrid_r;
   logic [IOPMPNumChan-1:0]          rsp_valid_r, rsp_err_r;
   logic [IOPMPNumChan-1:0][IOPMP_IDX_W-1:0] rsp_idx_r;

   assign req_ready_o   = grant_s;
   assign chk_valid_o   = pipe_vld_r[0];
   assign chk_addr_o    = chk_addr_r;
   assign chk_type_o    = chk_type_r;
   assign chk_rrid_o    = chk_rrid_r;
   assign rsp_valid_o   = rsp_valid_r;
   assign rsp_err_o     = rsp_err_r;
   assign rsp_idx_o     = rsp_idx_r;
   assign cfg_upd_ack_o = ack_r;

   assign res_vld_s  = pipe_vld_r[CHECK_LAT];
   assign res_chan_s = pipe_chan_r[CHECK_LAT];
   assign inflight_s = |pipe_vld_r;

   // A channel competes only when idle and the arbiter is allowed to issue.
   always_comb begin
      eligible_s = req_valid_i & ~busy_r & {IOPMPNumChan{grant_en_s}};
   end

   iopmp_check_arbiter_rr #(
      .N  (IOPMPNumChan),
      .IW (CW)
   ) u_rr (
      .eligible  (eligible_s),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_vld (grant_vld_s)
   );

   // Pointer moves just past the winner; it stays put when nobody is granted.
   always_comb begin
      if (grant_vld_s) begin
         if (grant_idx_s == CW'(IOPMPNumChan - 32'd1)) begin
            ptr_next_s = {CW{1'b0}};
         end else begin
            ptr_next_s = grant_idx_s + CW'(1'b1);
         end
      end else begin
         ptr_next_s = ptr_r;
      end
   end

   // One-hot owner of the result arriving this cycle; frees it and fires its rsp.
   always_comb begin
      rsp_clr_s = {IOPMPNumChan{1'b0}};
      if (res_vld_s) begin
         rsp_clr_s[res_chan_s] = 1'b1;
      end else begin
         rsp_clr_s = {IOPMPNumChan{1'b0}};
      end
   end

   // Update-handshake FSM next state; a dropped request always wins back to RUN.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ARB_RUN: begin
            if (cfg_upd_req_i) state_next_s = ARB_DRAIN;
            else               state_next_s = ARB_RUN;
         end
         ARB_DRAIN: begin
            if (!cfg_upd_req_i)   state_next_s = ARB_RUN;
            else if (!inflight_s) state_next_s = ARB_HOLD;
            else                  state_next_s = ARB_DRAIN;
         end
         ARB_HOLD: begin
            if (!cfg_upd_req_i) state_next_s = ARB_RUN;
            else                state_next_s = ARB_HOLD;
         end
         default: state_next_s = ARB_RUN;
      endcase
   end

   // FSM outputs: grant enable and the value the ack register takes next.
   always_comb begin
      grant_en_s = (state_r == ARB_RUN) && !cfg_upd_req_i;
      ack_next_s = (state_next_s == ARB_HOLD);
   end

   // FSM state, round-robin pointer and registered ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ARB_RUN;
         ptr_r   <= {CW{1'b0}};
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ptr_r   <= ptr_next_s;
         ack_r   <= ack_next_s;
      end
   end

   // Busy bits and the {valid,chan} pipe tracking each check to its owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r      <= {IOPMPNumChan{1'b0}};
         pipe_vld_r  <= {(CHECK_LAT + 1){1'b0}};
         pipe_chan_r <= {((CHECK_LAT + 1) * CW){1'b0}};
      end else begin
         busy_r         <= (busy_r & ~rsp_clr_s) | grant_s;
         pipe_vld_r[0]  <= grant_vld_s;
         pipe_chan_r[0] <= grant_idx_s;
         for (int k = 1; k <= int'(CHECK_LAT); k++) begin
            pipe_vld_r[k]  <= pipe_vld_r[k-1];
            pipe_chan_r[k] <= pipe_chan_r[k-1];
         end
      end
   end

   // Capture the granted request toward the checker.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_addr_r <= {IOPMP_ADDR_W{1'b0}};
         chk_type_r <= IOPMP_READ;
         chk_rrid_r <= {SourceWidth{1'b0}};
      end else if (grant_vld_s) begin
         chk_addr_r <= req_addr_i[grant_idx_s];
         chk_type_r <= iopmp_req_e'(req_type_i[grant_idx_s]);
         chk_rrid_r <= req_rrid_i[grant_idx_s];
      end else begin
         chk_addr_r <= chk_addr_r;
         chk_type_r <= chk_type_r;
         chk_rrid_r <= chk_rrid_r;
      end
   end

   // Route checker result to its channel; err/idx hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_r <= {IOPMPNumChan{1'b0}};
         rsp_err_r   <= {IOPMPNumChan{1'b0}};
         rsp_idx_r   <= {(IOPMPNumChan * IOPMP_IDX_W){1'b0}};
      end else begin
         rsp_valid_r <= rsp_clr_s;
         if (res_vld_s) begin
            rsp_err_r[res_chan_s] <= chk_err_i;
            rsp_idx_r[res_chan_s] <= chk_idx_i;
         end else begin
            rsp_err_r <= rsp_err_r;
            rsp_idx_r <= rsp_idx_r;
         end
      end
   end

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Directed bench for iopmp_check_arbiter (3 channels, checker latency 1).
// Stimulus pushes expected issues/responses into queues; a monitor pops and
// compares whenever the DUT presents chk_valid_o or rsp_valid_o.
module tb_iopmp_check_arbiter;
   import iopmp_check_arbiter_pkg::*;

   typedef struct {
      int          cyc;
      logic [33:0] addr;
      logic [1:0]  typ;
      logic [7:0]  rrid;
   } iss_t;

   typedef struct {
      int         cyc;
      int         chan;
      logic       err;
      logic [8:0] idx;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        req_valid_i;
   logic [2:0]        req_ready_o;
   logic [2:0][33:0]  req_addr_i;
   logic [2:0][1:0]   req_type_i;
   logic [2:0][7:0]   req_rrid_i;
   logic              chk_valid_o;
   logic [33:0]       chk_addr_o;
   iopmp_req_e        chk_type_o;
   logic [7:0]        chk_rrid_o;
   logic              chk_err_i;
   logic [8:0]        chk_idx_i;
   logic [2:0]        rsp_valid_o;
   logic [2:0]        rsp_err_o;
   logic [2:0][8:0]   rsp_idx_o;
   logic              cfg_upd_req_i;
   logic              cfg_upd_ack_o;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   iss_t iss_q[$];
   rsp_t rsp_q[$];

   iopmp_check_arbiter #(.IOPMPNumChan(3), .CHECK_LAT(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_addr_i    (req_addr_i),
      .req_type_i    (req_type_i),
      .req_rrid_i    (req_rrid_i),
      .chk_valid_o   (chk_valid_o),
      .chk_addr_o    (chk_addr_o),
      .chk_type_o    (chk_type_o),
      .chk_rrid_o    (chk_rrid_o),
      .chk_err_i     (chk_err_i),
      .chk_idx_i     (chk_idx_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_idx_o     (rsp_idx_o),
      .cfg_upd_req_i (cfg_upd_req_i),
      .cfg_upd_ack_o (cfg_upd_ack_o)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Checker stand-in: deny when addr[12] set, index = addr[20:12]*5.
   function automatic logic model_err(input logic [33:0] a);
      return a[12];
   endfunction

   function automatic logic [8:0] model_idx(input logic [33:0] a);
      return 9'(a[20:12] * 9'd5);
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int n, input logic [33:0] a, input logic [1:0] t, input logic [7:0] r);
      req_addr_i[n] = a;
      req_type_i[n] = t;
      req_rrid_i[n] = r;
   endtask

   // Compare ready against the hand-computed grant and queue what must follow.
   task automatic expect_grant(input logic [2:0] exp, input bit push_rsp);
      iss_t ie;
      rsp_t re;
      #2;
      cmp("req_ready", 64'(req_ready_o), 64'(exp));
      for (int n = 0; n < 3; n++) begin
         if (exp[n]) begin
            ie.cyc  = cyc + 1;
            ie.addr = req_addr_i[n];
            ie.typ  = req_type_i[n];
            ie.rrid = req_rrid_i[n];
            iss_q.push_back(ie);
            if (push_rsp) begin
               re.cyc  = cyc + 3;
               re.chan = n;
               re.err  = model_err(req_addr_i[n]);
               re.idx  = model_idx(req_addr_i[n]);
               rsp_q.push_back(re);
            end
         end
      end
   endtask

   // Checker response, one cycle after the issue is seen.
   initial begin
      logic       pend_err;
      logic [8:0] pend_idx;
      pend_err  = 1'b1;
      pend_idx  = 9'h1FF;
      chk_err_i = 1'b0;
      chk_idx_i = 9'd0;
      forever begin
         @(negedge clk);
         chk_err_i = pend_err;
         chk_idx_i = pend_idx;
         if (chk_valid_o === 1'b1) begin
            pend_err = model_err(chk_addr_o);
            pend_idx = model_idx(chk_addr_o);
         end else begin
            pend_err = 1'b1;
            pend_idx = 9'h1FF;
         end
      end
   end

   // Monitor: pop and compare whenever the DUT issues or responds.
   initial begin
      iss_t ie;
      rsp_t re;
      forever begin
         @(negedge clk);
         if (chk_valid_o === 1'b1) begin
            checks++;
            if (iss_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue: chk_addr 0x%0h at cycle %0d, none expected", chk_addr_o, cyc);
            end else begin
               ie = iss_q.pop_front();
               cmp("issue_cycle", 64'(cyc), 64'(ie.cyc));
               cmp("chk_addr", 64'(chk_addr_o), 64'(ie.addr));
               cmp("chk_type", 64'(chk_type_o), 64'(ie.typ));
               cmp("chk_rrid", 64'(chk_rrid_o), 64'(ie.rrid));
            end
         end
         for (int n = 0; n < 3; n++) begin
            if (rsp_valid_o[n] === 1'b1) begin
               checks++;
               if (rsp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rsp: channel %0d at cycle %0d, none expected", n, cyc);
               end else begin
                  re = rsp_q.pop_front();
                  cmp("rsp_chan", 64'(n), 64'(re.chan));
                  cmp("rsp_cycle", 64'(cyc), 64'(re.cyc));
                  cmp("rsp_err", 64'(rsp_err_o[n]), 64'(re.err));
                  cmp("rsp_idx", 64'(rsp_idx_o[n]), 64'(re.idx));
               end
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      cfg_upd_req_i = 1'b1;
      req_valid_i   = 3'b000;
      req_addr_i    = '0;
      req_type_i    = '0;
      req_rrid_i    = '0;

      // Reset state
      repeat (3) tick();
      #2;
      cmp("rst_chk_valid", 64'(chk_valid_o), 64'd0);
      cmp("rst_chk_addr", 64'(chk_addr_o), 64'd0);
      cmp("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      cmp("rst_rsp_err", 64'(rsp_err_o), 64'd0);
      cmp("rst_rsp_idx", 64'(rsp_idx_o), 64'd0);
      cmp("rst_ack", 64'(cfg_upd_ack_o), 64'd0);

      // Update request held through reset release: ack two cycles later
      tick(); rst = 1'b0;
      #2 cmp("ack_r0", 64'(cfg_upd_ack_o), 64'd0);
      tick(); #2 cmp("ack_r1", 64'(cfg_upd_ack_o), 64'd0);
      tick(); #2 cmp("ack_r2", 64'(cfg_upd_ack_o), 64'd1);
      tick(); cfg_upd_req_i = 1'b0;
      #2 cmp("ack_r3", 64'(cfg_upd_ack_o), 64'd1);
      tick(); #2 cmp("ack_r4", 64'(cfg_upd_ack_o), 64'd0);

      // Single ch1 read at 0x1000: deny, index 5
      tick();
      set_req(1, 34'h1000, IOPMP_READ, 8'h11);
      req_valid_i = 3'b010;
      expect_grant(3'b010, 1'b1);
      tick(); req_valid_i = 3'b000; expect_grant(3'b000, 1'b1);
      repeat (4) tick();
      #2;
      cmp("hold_rsp_err1", 64'(rsp_err_o[1]), 64'd1);
      cmp("hold_rsp_idx1", 64'(rsp_idx_o[1]), 64'd5);
      cmp("hold_rsp_valid", 64'(rsp_valid_o), 64'd0);

      // Reset, then all three held valid: 0,1,2,0,1,2
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      set_req(0, 34'h2000, IOPMP_READ,    8'hA0);
      set_req(1, 34'h3000, IOPMP_WRITE,   8'hA1);
      set_req(2, 34'h4000, IOPMP_EXECUTE, 8'hA2);
      req_valid_i = 3'b111;
      expect_grant(3'b001, 1'b1);
      tick(); expect_grant(3'b010, 1'b1);
      tick(); expect_grant(3'b100, 1'b1);
      tick(); expect_grant(3'b001, 1'b1);
      tick(); expect_grant(3'b010, 1'b1);
      tick(); expect_grant(3'b100, 1'b1);
      tick(); req_valid_i = 3'b000; expect_grant(3'b000, 1'b1);
      repeat (5) tick();

      // ch0 continuous, ch2 once: ch0, ch2, ch0; ch0 never granted while busy
      set_req(0, 34'h5000, IOPMP_WRITE, 8'h30);
      set_req(2, 34'h6000, IOPMP_READ,  8'h32);
      req_valid_i = 3'b101;
      expect_grant(3'b001, 1'b1);
      tick(); expect_grant(3'b100, 1'b1);
      tick(); req_valid_i = 3'b001; expect_grant(3'b000, 1'b1);
      tick(); expect_grant(3'b001, 1'b1);
      tick(); expect_grant(3'b000, 1'b1);
      tick(); expect_grant(3'b000, 1'b1);
      tick(); expect_grant(3'b001, 1'b1);
      tick(); req_valid_i = 3'b000; expect_grant(3'b000, 1'b1);
      repeat (5) tick();

      // Update request with two checks in flight, then release from HOLD
      set_req(1, 34'h7000, IOPMP_READ,    8'h41);
      set_req(2, 34'h8000, IOPMP_WRITE,   8'h42);
      set_req(0, 34'h9000, IOPMP_EXECUTE, 8'h40);
      req_valid_i = 3'b110;
      expect_grant(3'b010, 1'b1);
      tick(); expect_grant(3'b100, 1'b1);
      tick(); req_valid_i = 3'b001; cfg_upd_req_i = 1'b1;
      expect_grant(3'b000, 1'b1); cmp("ack_c2", 64'(cfg_upd_ack_o), 64'd0);
      tick(); expect_grant(3'b000, 1'b1); cmp("ack_c3", 64'(cfg_upd_ack_o), 64'd0);
      tick(); expect_grant(3'b000, 1'b1); cmp("ack_c4", 64'(cfg_upd_ack_o), 64'd0);
      tick(); expect_grant(3'b000, 1'b1); cmp("ack_c5", 64'(cfg_upd_ack_o), 64'd1);
      tick(); expect_grant(3'b000, 1'b1); cmp("ack_c6", 64'(cfg_upd_ack_o), 64'd1);
      tick(); cfg_upd_req_i = 1'b0;
      expect_grant(3'b000, 1'b1); cmp("ack_c7", 64'(cfg_upd_ack_o), 64'd1);
      tick(); expect_grant(3'b001, 1'b1); cmp("ack_c8", 64'(cfg_upd_ack_o), 64'd0);
      tick(); req_valid_i = 3'b000; expect_grant(3'b000, 1'b1);
      repeat (5) tick();

      // Reset pulse with two checks in flight: no responses, ch0 first after
      set_req(1, 34'h0000A000, IOPMP_READ,  8'h51);
      set_req(2, 34'h0000B000, IOPMP_WRITE, 8'h52);
      set_req(0, 34'h0000C000, IOPMP_READ,  8'h50);
      req_valid_i = 3'b110;
      expect_grant(3'b010, 1'b0);
      tick(); expect_grant(3'b100, 1'b0);
      tick(); rst = 1'b1; req_valid_i = 3'b000; expect_grant(3'b000, 1'b0);
      tick(); rst = 1'b0; req_valid_i = 3'b111;
      expect_grant(3'b001, 1'b1);
      cmp("post_rst_chk_valid", 64'(chk_valid_o), 64'd0);
      cmp("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      tick(); expect_grant(3'b010, 1'b1);
      tick(); expect_grant(3'b100, 1'b1);
      tick(); req_valid_i = 3'b000; expect_grant(3'b000, 1'b1);
      repeat (6) tick();

      cmp("issues_outstanding", 64'(iss_q.size()), 64'd0);
      cmp("rsps_outstanding", 64'(rsp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
